// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: frame states, frame geometry and the baud_select rate map.
// The receiver imports the same package so both ends agree on the codes.
package uart_transmitter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;

    localparam logic [2:0] BAUD_300    = 3'b000;
    localparam logic [2:0] BAUD_1200   = 3'b001;
    localparam logic [2:0] BAUD_4800   = 3'b010;
    localparam logic [2:0] BAUD_9600   = 3'b011;
    localparam logic [2:0] BAUD_19200  = 3'b100;
    localparam logic [2:0] BAUD_38400  = 3'b101;
    localparam logic [2:0] BAUD_57600  = 3'b110;
    localparam logic [2:0] BAUD_115200 = 3'b111;

    localparam int DIV_WIDTH = 14;

    // Clocks per sample strobe for a 50 MHz clk, i.e. 50e6 / (16 * baud), rounded.
    function automatic logic [DIV_WIDTH-1:0] baud_divisor(input logic [2:0] code);
        baud_divisor = 14'd27;
        case (code)
            BAUD_300:    baud_divisor = 14'd10417;
            BAUD_1200:   baud_divisor = 14'd2604;
            BAUD_4800:   baud_divisor = 14'd651;
            BAUD_9600:   baud_divisor = 14'd326;
            BAUD_19200:  baud_divisor = 14'd163;
            BAUD_38400:  baud_divisor = 14'd81;
            BAUD_57600:  baud_divisor = 14'd54;
            BAUD_115200: baud_divisor = 14'd27;
        endcase
    endfunction

endpackage

// File: rtl/uart_transmitter_baud_controller.sv
// Free-running divider producing a one-clock sample_enable strobe at 16x the selected baud rate.
module uart_transmitter_baud_controller
    import uart_transmitter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       sample_enable
);

    logic [DIV_WIDTH-1:0] count;
    logic [DIV_WIDTH-1:0] limit;

    assign limit = baud_divisor(baud_select) - DIV_WIDTH'(1);

    // NOTE: '>=' rather than '==' so a switch to a faster rate with the count
    // already past the new limit wraps at once instead of running to 2^14.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count         <= '0;
            sample_enable <= 1'b0;
        end else if (count >= limit) begin
            count         <= '0;
            sample_enable <= 1'b1;
        end else begin
            count         <= count + 1'b1;
            sample_enable <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART TX: start bit, DATA_BITS data bits LSB first, parity, stop bit, paced by the 16x sample strobe.
// TxD and Tx_BUSY are registered; rate and payload are frozen at the accepted write.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] Tx_DATA,
    input  logic [2:0]           baud_select,
    input  logic                 Tx_EN,
    input  logic                 Tx_WR,
    output logic                 TxD,
    output logic                 Tx_BUSY
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);

    tx_state_t            state;
    logic [2:0]           baud_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 parity_q;
    logic [CNT_W-1:0]     sample_cnt;
    logic [IDX_W-1:0]     bit_idx;

    logic sample_enable;
    logic accept;
    logic bit_end;
    logic parity_next;

    uart_transmitter_baud_controller baud_controller (
        .clk           (clk),
        .reset         (reset),
        .baud_select   (baud_q),
        .sample_enable (sample_enable)
    );

    assign accept      = Tx_WR && Tx_EN && (state == IDLE);
    assign bit_end     = sample_enable && (sample_cnt == CNT_W'(OVERSAMPLE - 1));
    assign parity_next = (PARITY_ODD != 0) ? ~^Tx_DATA : ^Tx_DATA;

    // NOTE: every register, payload included, has an async reset so a reset
    // mid-frame leaves no stale byte or rate behind for the next write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            TxD        <= 1'b1;
            Tx_BUSY    <= 1'b0;
            sample_cnt <= '0;
            bit_idx    <= '0;
            data_q     <= '0;
            baud_q     <= BAUD_300;
            parity_q   <= 1'b0;
        end else begin
            // The divider is free-running, so the start bit absorbs its phase.
            if (accept || bit_end) begin
                sample_cnt <= '0;
            end else if (sample_enable) begin
                sample_cnt <= sample_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    TxD     <= 1'b1;
                    Tx_BUSY <= 1'b0;
                    if (accept) begin
                        data_q   <= Tx_DATA;
                        baud_q   <= baud_select;
                        parity_q <= parity_next;
                        bit_idx  <= '0;
                        state    <= START;
                        TxD      <= 1'b0;
                        Tx_BUSY  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        TxD     <= data_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            state <= PARITY;
                            TxD   <= parity_q;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            TxD     <= data_q[bit_idx + 1'b1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        TxD   <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state   <= IDLE;
                        TxD     <= 1'b1;
                        Tx_BUSY <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    TxD     <= 1'b1;
                    Tx_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frame shape and exact bit timing, dropped writes,
// enable and rate changes mid-frame, asynchronous reset and back-to-back writes.
module tb_uart_transmitter;
    import uart_transmitter_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] Tx_DATA = 8'h00;
    logic [2:0] baud_select = 3'b000;
    logic       Tx_EN = 1'b0;
    logic       Tx_WR = 1'b0;
    logic       TxD;
    logic       Tx_BUSY;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_transmitter dut (
        .clk         (clk),
        .reset       (reset),
        .Tx_DATA     (Tx_DATA),
        .baud_select (baud_select),
        .Tx_EN       (Tx_EN),
        .Tx_WR       (Tx_WR),
        .TxD         (TxD),
        .Tx_BUSY     (Tx_BUSY)
    );

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Returns on the negedge just after the accepting posedge.
    task automatic do_write(input logic [7:0] d, input logic [2:0] b);
        @(negedge clk);
        Tx_DATA     = d;
        baud_select = b;
        Tx_WR       = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
    endtask

    // Entered on the first cycle after accept; returns on the first idle cycle after stop.
    task automatic check_frame(input logic [7:0] d, input logic par, input int div, input string tag);
        int period;
        int start_len;
        logic [FRAME_BITS-2:0] bits;
        period = OVERSAMPLE * div;
        bits   = {1'b1, par, d};

        checks++;
        if (TxD !== 1'b0 || Tx_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: TxD=%b Tx_BUSY=%b expected 0 1", tag, TxD, Tx_BUSY);
        end

        start_len = 0;
        while (TxD === 1'b0 && start_len <= period + div) begin
            start_len++;
            @(negedge clk);
        end
        checks++;
        if (start_len < period - div || start_len > period) begin
            errors++;
            $display("FAIL %s start_len: got %0d clk expected %0d..%0d", tag, start_len, period - div, period);
        end

        for (int k = 0; k < FRAME_BITS - 1; k++) begin
            checks++;
            if (TxD !== bits[k]) begin
                errors++;
                $display("FAIL %s bit%0d first cycle: TxD=%b expected %b", tag, k, TxD, bits[k]);
            end
            repeat (period - 1) @(negedge clk);
            checks++;
            if (TxD !== bits[k] || Tx_BUSY !== 1'b1) begin
                errors++;
                $display("FAIL %s bit%0d last cycle: TxD=%b Tx_BUSY=%b expected %b 1",
                         tag, k, TxD, Tx_BUSY, bits[k]);
            end
            @(negedge clk);
        end

        checks++;
        if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL %s idle after stop: TxD=%b Tx_BUSY=%b expected 1 0", tag, TxD, Tx_BUSY);
        end
    endtask

    task automatic test_reset();
        int bad;
        apply_reset();
        checks++;
        if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: TxD=%b Tx_BUSY=%b expected 1 0", TxD, Tx_BUSY);
        end
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_idle: %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_single_frame();
        Tx_EN = 1'b1;
        do_write(8'hA5, BAUD_115200);
        check_frame(8'hA5, 1'b0, 27, "a5");
    endtask

    task automatic test_write_while_busy();
        int bad;
        do_write(8'hA5, BAUD_115200);
        fork
            check_frame(8'hA5, 1'b0, 27, "a5_busy");
            begin
                Tx_DATA = 8'h3C;
                Tx_WR   = 1'b1;
                @(negedge clk);
                Tx_WR = 1'b0;
                repeat (98) @(negedge clk);
                Tx_WR = 1'b1;
                @(negedge clk);
                Tx_WR = 1'b0;
                repeat (2899) @(negedge clk);
                Tx_WR = 1'b1;
                @(negedge clk);
                Tx_WR = 1'b0;
            end
        join
        bad = 0;
        repeat (600) begin
            @(negedge clk);
            if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL busy_write_dropped: %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_enable();
        int bad;
        Tx_EN = 1'b0;
        do_write(8'h55, BAUD_115200);
        bad = 0;
        repeat (10000) begin
            if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL disabled_write_dropped: %0d active cycles expected 0", bad);
        end
        Tx_EN = 1'b1;
        do_write(8'h55, BAUD_115200);
        fork
            check_frame(8'h55, 1'b0, 27, "55_en_drop");
            begin
                repeat (1927) @(negedge clk);
                Tx_EN = 1'b0;
            end
        join
        Tx_EN = 1'b1;
    endtask

    task automatic test_mid_frame_reset();
        do_write(8'hF0, BAUD_115200);
        repeat (2359) @(negedge clk);
        checks++;
        if (TxD !== 1'b1 || Tx_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL f0_bit4: TxD=%b Tx_BUSY=%b expected 1 1", TxD, Tx_BUSY);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: TxD=%b Tx_BUSY=%b expected 1 0", TxD, Tx_BUSY);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        do_write(8'h81, BAUD_115200);
        check_frame(8'h81, 1'b0, 27, "81_after_reset");
    endtask

    task automatic test_back_to_back();
        int bad;
        do_write(8'hFF, BAUD_57600);
        fork
            check_frame(8'hFF, 1'b0, 54, "ff_baud_switch");
            begin
                repeat (2999) @(negedge clk);
                baud_select = BAUD_300;
            end
        join
        Tx_DATA = 8'h07;
        Tx_WR   = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
        checks++;
        if (TxD !== 1'b0 || Tx_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: TxD=%b Tx_BUSY=%b expected 0 1", TxD, Tx_BUSY);
        end
        bad = 0;
        repeat (20000) begin
            @(negedge clk);
            if (TxD !== 1'b0 || Tx_BUSY !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL b2b_slow_start: %0d cycles left start bit expected 0", bad);
        end
        apply_reset();
        do_write(8'h07, BAUD_115200);
        check_frame(8'h07, 1'b1, 27, "07_parity");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_write_while_busy();
        test_enable();
        test_mid_frame_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
